// File: rtl/tpu_tile_scheduler_if.sv
// Command/TPU/status bundle between the CFU decoder, the tile scheduler and the TPU core.
// master = scheduler side, slave = decoder + TPU side.
interface tpu_tile_scheduler_if #(
  parameter int NT_W = 10,
  parameter int B_AW = 19,
  parameter int C_AW = 32
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [12:0]     cmd_k;
  logic [12:0]     cmd_m_round;
  logic [NT_W-1:0] cmd_n_tiles;
  logic [8:0]      cmd_in_off;
  logic [C_AW-1:0] cmd_c_base;
  logic            tpu_in_valid;
  logic [12:0]     tpu_k;
  logic [12:0]     tpu_m_round;
  logic [8:0]      tpu_in_off;
  logic            tpu_busy;
  logic            tpu_c_wr_en;
  logic [B_AW-1:0] b_base;
  logic [13:0]     bias_base;
  logic [C_AW-1:0] c_index;
  logic [NT_W-1:0] cur_tile;
  logic            done;
  logic            err;

  modport master (
    input  cmd_valid, cmd_k, cmd_m_round, cmd_n_tiles, cmd_in_off, cmd_c_base,
           tpu_busy, tpu_c_wr_en,
    output cmd_ready, tpu_in_valid, tpu_k, tpu_m_round, tpu_in_off,
           b_base, bias_base, c_index, cur_tile, done, err
  );

  modport slave (
    output cmd_valid, cmd_k, cmd_m_round, cmd_n_tiles, cmd_in_off, cmd_c_base,
           tpu_busy, tpu_c_wr_en,
    input  cmd_ready, tpu_in_valid, tpu_k, tpu_m_round, tpu_in_off,
           b_base, bias_base, c_index, cur_tile, done, err
  );
endinterface

// File: rtl/tpu_tile_scheduler.sv
// Layer-level matmul sequencer: one TPU job per TILE_N-column N-tile, with running
// B/bias base offsets, C_index generation and a per-job beat-count check.
module tpu_tile_scheduler #(
  parameter int NT_W   = 10,
  parameter int B_AW   = 19,
  parameter int C_AW   = 32,
  parameter int TILE_N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tpu_tile_scheduler_if.master bus
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, RUN, CHECK, DONE} state_e;

  state_e          state_q, state_d;
  logic [12:0]     k_q, k_d;
  logic [12:0]     m_q, m_d;
  logic [NT_W-1:0] n_q, n_d;
  logic [8:0]      off_q, off_d;
  logic [B_AW-1:0] b_base_q, b_base_d;
  logic [13:0]     bias_q, bias_d;
  logic [C_AW-1:0] c_idx_q, c_idx_d;
  logic [NT_W-1:0] tile_q, tile_d;
  logic [12:0]     beat_q, beat_d;
  logic            err_q, err_d;
  logic [NT_W:0]   tile_inc;

  // one bit wider so the last-tile compare cannot alias on wrap
  assign tile_inc = {1'b0, tile_q} + {{NT_W{1'b0}}, 1'b1};

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    m_d      = m_q;
    n_d      = n_q;
    off_d    = off_q;
    b_base_d = b_base_q;
    bias_d   = bias_q;
    c_idx_d  = c_idx_q;
    tile_d   = tile_q;
    beat_d   = beat_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        k_d      = bus.cmd_k;
        m_d      = bus.cmd_m_round;
        n_d      = bus.cmd_n_tiles;
        off_d    = bus.cmd_in_off;
        b_base_d = '0;
        bias_d   = '0;
        tile_d   = '0;
        err_d    = 1'b0;
        c_idx_d  = bus.cmd_c_base;
        state_d  = (bus.cmd_n_tiles == '0 || bus.cmd_m_round == '0) ? DONE : LAUNCH;
      end
      LAUNCH: begin
        beat_d  = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: if (bus.tpu_busy) state_d = RUN;
      RUN: begin
        // a beat in the busy-fall cycle still lands before CHECK
        if (bus.tpu_c_wr_en) begin
          c_idx_d = c_idx_q + C_AW'(1);
          beat_d  = beat_q + 13'd1;
        end
        if (!bus.tpu_busy) state_d = CHECK;
      end
      CHECK: begin
        if (beat_q != m_q) err_d = 1'b1;
        if (tile_inc == {1'b0, n_q}) begin
          state_d = DONE;
        end else begin
          tile_d   = tile_inc[NT_W-1:0];
          b_base_d = b_base_q + B_AW'(k_q);
          bias_d   = bias_q + 14'(TILE_N);
          state_d  = LAUNCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      m_q      <= '0;
      n_q      <= '0;
      off_q    <= '0;
      b_base_q <= '0;
      bias_q   <= '0;
      c_idx_q  <= '0;
      tile_q   <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      m_q      <= m_d;
      n_q      <= n_d;
      off_q    <= off_d;
      b_base_q <= b_base_d;
      bias_q   <= bias_d;
      c_idx_q  <= c_idx_d;
      tile_q   <= tile_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
    end
  end

  assign bus.cmd_ready    = (state_q == IDLE);
  assign bus.tpu_in_valid = (state_q == LAUNCH);
  assign bus.done         = (state_q == DONE);
  assign bus.tpu_k        = k_q;
  assign bus.tpu_m_round  = m_q;
  assign bus.tpu_in_off   = off_q;
  assign bus.b_base       = b_base_q;
  assign bus.bias_base    = bias_q;
  assign bus.c_index      = c_idx_q;
  assign bus.cur_tile     = tile_q;
  assign bus.err          = err_q;

endmodule
